// File: rtl/cpu_pkg.sv
// Shared types and pre-decode helpers for the SM83 fetch front end.
// FETCH_ILLEGAL_TRAP_EN adds the illegal flag to queued entries.
package cpu_pkg;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef enum logic [1:0] {
        S_OP     = 2'd0,
        S_CB     = 2'd1,
        S_IMM_LO = 2'd2,
        S_IMM_HI = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } entry_t;

    function automatic logic [1:0] imm_len(input logic [7:0] op);
        logic [1:0] n;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                n = 2'd1;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
            8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                n = 2'd2;
            default:
                n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        logic ill;
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
                ill = 1'b1;
            default:
                ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// Synchronous FIFO of assembled instruction entries with flush.
// Flush overrides any push or pop on the same edge; pop on empty is ignored.
module cpu_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_flush,
    input  logic          i_push,
    input  entry_t        i_push_data,
    input  logic          i_pop,
    output entry_t        o_head,
    output logic [CW-1:0] o_count
);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    always_ff @(posedge clk_in) begin
        if (rst_in || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_do_push)
            r_mem[r_wr] <= i_push_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/cpu_fetch_unit.sv
// SM83 fetch/pre-decode: assembles opcode, CB prefix and immediates into a queue.
// FETCH_ILLEGAL_TRAP_EN adds instr_illegal and a fetch trap on illegal opcodes.
//
// state    | meaning
// S_OP     | expecting the first byte of an instruction
// S_CB     | CB prefix seen, expecting the prefixed opcode
// S_IMM_LO | expecting immediate low byte
// S_IMM_HI | expecting immediate high byte of a 16-bit immediate
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mclk_in,
    output logic        fetch_req,
    input  logic        bus_gnt,
    output logic [15:0] fetch_addr,
    input  logic [7:0]  mem_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic        instr_cb,
`ifdef FETCH_ILLEGAL_TRAP_EN
    output logic        instr_illegal,
`endif
    output logic [15:0] instr_imm,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [15:0]   r_pc;
    logic [15:0]   r_entry_pc;
    logic [7:0]    r_opcode;
    logic [7:0]    r_imm_lo;
    logic          w_capture;
    logic          w_push;
    logic          w_set_trap;
    logic          w_trapped;
    entry_t        w_entry;
    entry_t        w_head;
    logic [CW-1:0] w_count;

    assign fetch_addr = r_pc;
    assign fetch_req  = (w_count != CW'(QUEUE_DEPTH)) && !w_trapped;
    assign w_capture  = mclk_in && bus_gnt && fetch_req;
    assign instr_valid = (w_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_trap  = 1'b0;
        w_entry     = '0;
        if (w_capture) begin
            case (r_state)
                S_OP: begin
                    if (mem_in == CB_PREFIX) begin
                        w_state_nxt = S_CB;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    end else if (is_illegal(mem_in)) begin
                        w_push          = 1'b1;
                        w_set_trap      = 1'b1;
                        w_entry.opcode  = mem_in;
                        w_entry.len     = 2'd1;
                        w_entry.pc      = r_pc;
                        w_entry.illegal = 1'b1;
`endif
                    end else if (imm_len(mem_in) == 2'd0) begin
                        w_push         = 1'b1;
                        w_entry.opcode = mem_in;
                        w_entry.len    = 2'd1;
                        w_entry.pc     = r_pc;
                    end else begin
                        w_state_nxt = S_IMM_LO;
                    end
                end
                S_CB: begin
                    w_push         = 1'b1;
                    w_entry.opcode = mem_in;
                    w_entry.cb     = 1'b1;
                    w_entry.len    = 2'd2;
                    w_entry.pc     = r_entry_pc;
                    w_state_nxt    = S_OP;
                end
                S_IMM_LO: begin
                    if (imm_len(r_opcode) == 2'd1) begin
                        w_push         = 1'b1;
                        w_entry.opcode = r_opcode;
                        w_entry.imm    = {8'h00, mem_in};
                        w_entry.len    = 2'd2;
                        w_entry.pc     = r_entry_pc;
                        w_state_nxt    = S_OP;
                    end else begin
                        w_state_nxt = S_IMM_HI;
                    end
                end
                S_IMM_HI: begin
                    w_push         = 1'b1;
                    w_entry.opcode = r_opcode;
                    w_entry.imm    = {mem_in, r_imm_lo};
                    w_entry.len    = 2'd3;
                    w_entry.pc     = r_entry_pc;
                    w_state_nxt    = S_OP;
                end
                default: w_state_nxt = S_OP;
            endcase
        end
    end

    // Redirect outranks capture, so a byte arriving on that edge is dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_OP;
            r_pc       <= RESET_PC;
            r_entry_pc <= '0;
            r_opcode   <= '0;
            r_imm_lo   <= '0;
        end else if (redirect_valid) begin
            r_state <= S_OP;
            r_pc    <= redirect_pc;
        end else if (w_capture) begin
            r_state <= w_state_nxt;
            r_pc    <= r_pc + 16'd1;
            if (r_state == S_OP) begin
                r_entry_pc <= r_pc;
                r_opcode   <= mem_in;
            end
            if (r_state == S_IMM_LO)
                r_imm_lo <= mem_in;
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic r_trapped;

    always_ff @(posedge clk_in) begin
        if (rst_in || redirect_valid)
            r_trapped <= 1'b0;
        else if (w_set_trap)
            r_trapped <= 1'b1;
    end

    assign w_trapped     = r_trapped;
    assign instr_illegal = w_head.illegal;
`else
    assign w_trapped = 1'b0;
`endif

    cpu_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_entry),
        .i_pop       (instr_valid && instr_ready),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign instr_opcode = w_head.opcode;
    assign instr_cb     = w_head.cb;
    assign instr_imm    = w_head.imm;
    assign instr_len    = w_head.len;
    assign instr_pc     = w_head.pc;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with a byte-array memory model.
// Illegal-opcode checks follow FETCH_ILLEGAL_TRAP_EN.
module tb_cpu_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        mclk_in;
    logic        fetch_req;
    logic        bus_gnt;
    logic [15:0] fetch_addr;
    logic [7:0]  mem_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic        instr_cb;
    logic [15:0] instr_imm;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic        instr_illegal;
`endif

    logic [7:0] tb_mem [0:65535];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    assign mem_in = tb_mem[fetch_addr];

    cpu_fetch_unit #(
        .QUEUE_DEPTH (2),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mclk_in        (mclk_in),
        .fetch_req      (fetch_req),
        .bus_gnt        (bus_gnt),
        .fetch_addr     (fetch_addr),
        .mem_in         (mem_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_cb       (instr_cb),
`ifdef FETCH_ILLEGAL_TRAP_EN
        .instr_illegal  (instr_illegal),
`endif
        .instr_imm      (instr_imm),
        .instr_len      (instr_len),
        .instr_pc       (instr_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One M-cycle of four clocks; the strobe is high for the first.
    task automatic mcycle();
        @(negedge clk_in); mclk_in = 1'b1;
        @(negedge clk_in); mclk_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic pop();
        @(negedge clk_in); instr_ready = 1'b1;
        @(negedge clk_in); instr_ready = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] pc);
        @(negedge clk_in); redirect_valid = 1'b1; redirect_pc = pc;
        @(negedge clk_in); redirect_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] op, input logic cb,
                              input logic [15:0] imm, input logic [1:0] len, input logic [15:0] pc);
        check({tag, ".valid"},  instr_valid,  1);
        check({tag, ".opcode"}, instr_opcode, op);
        check({tag, ".cb"},     instr_cb,     cb);
        check({tag, ".imm"},    instr_imm,    imm);
        check({tag, ".len"},    instr_len,    len);
        check({tag, ".pc"},     instr_pc,     pc);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        tb_mem[16'h0100] = 8'hC3; tb_mem[16'h0101] = 8'h50; tb_mem[16'h0102] = 8'h01;
        tb_mem[16'h0103] = 8'hCB; tb_mem[16'h0104] = 8'h37;
        tb_mem[16'h0105] = 8'h3E; tb_mem[16'h0106] = 8'h42;
        tb_mem[16'h0107] = 8'h00; tb_mem[16'h0108] = 8'h01;
        tb_mem[16'h0109] = 8'h34; tb_mem[16'h010A] = 8'h12;
        tb_mem[16'h0038] = 8'h06; tb_mem[16'h0039] = 8'h77;
        tb_mem[16'hFFFF] = 8'h00;
        tb_mem[16'h0200] = 8'hD3;

        rst_in = 1'b1; mclk_in = 1'b0; bus_gnt = 1'b1; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        repeat (3) @(negedge clk_in);
        check("rst.fetch_addr", fetch_addr,   16'h0000);
        check("rst.fetch_req",  fetch_req,    1);
        check("rst.valid",      instr_valid,  0);
        check("rst.opcode",     instr_opcode, 0);
        check("rst.imm",        instr_imm,    0);
        check("rst.len",        instr_len,    0);
        check("rst.pc",         instr_pc,     0);
        rst_in = 1'b0;

        mcycle();
        check_head("nop0", 8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000);
        check("nop0.fetch_addr", fetch_addr, 16'h0001);
        check("nop0.fetch_req",  fetch_req,  1);
        mcycle();
        check("full.fetch_req",  fetch_req,  0);
        check("full.fetch_addr", fetch_addr, 16'h0002);
        check("full.head_pc",    instr_pc,   16'h0000);
        mcycle();
        check("full.hold_addr",  fetch_addr, 16'h0002);
        pop();
        check("pop1.fetch_req",  fetch_req,  1);
        check_head("nop1", 8'h00, 1'b0, 16'h0000, 2'd1, 16'h0001);
        pop();
        check("pop2.valid", instr_valid, 0);

        redirect(16'h0100);
        check("jp.redir_addr", fetch_addr, 16'h0100);
        mcycle();
        mcycle();
        check("jp.partial_valid", instr_valid, 0);
        mcycle();
        check_head("jp", 8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0100);
        check("jp.fetch_addr", fetch_addr, 16'h0103);
        pop();

        mcycle();
        mcycle();
        check_head("cb37", 8'h37, 1'b1, 16'h0000, 2'd2, 16'h0103);
        mcycle();
        mcycle();
        check("cb37.still_head", instr_opcode, 8'h37);
        pop();
        check_head("ld3e", 8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0105);
        pop();
        check("ld3e.empty", instr_valid, 0);
        check("ld3e.fetch_addr", fetch_addr, 16'h0107);

        bus_gnt = 1'b0;
        mcycle();
        check("nognt.fetch_addr", fetch_addr, 16'h0107);
        check("nognt.valid",      instr_valid, 0);
        bus_gnt = 1'b1;

        mcycle();
        mcycle();
        mcycle();
        check("mid.valid",      instr_valid, 1);
        check("mid.fetch_addr", fetch_addr,  16'h010A);
        redirect(16'h0038);
        check("redir.valid",      instr_valid, 0);
        check("redir.fetch_addr", fetch_addr,  16'h0038);
        check("redir.fetch_req",  fetch_req,   1);
        mcycle();
        mcycle();
        check_head("ld06", 8'h06, 1'b0, 16'h0077, 2'd2, 16'h0038);
        pop();

        redirect(16'hFFFF);
        mcycle();
        check("wrap.fetch_addr", fetch_addr, 16'h0000);
        check_head("wrap", 8'h00, 1'b0, 16'h0000, 2'd1, 16'hFFFF);
        pop();

        redirect(16'h0200);
        mcycle();
        check_head("d3", 8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0200);
`ifdef FETCH_ILLEGAL_TRAP_EN
        check("trap.illegal",   instr_illegal, 1);
        check("trap.fetch_req", fetch_req,     0);
        mcycle();
        check("trap.hold_addr", fetch_addr,    16'h0201);
        pop();
        check("trap.empty",     instr_valid,   0);
        check("trap.req_empty", fetch_req,     0);
        redirect(16'h0000);
        check("trap.cleared",   fetch_req,     1);
`else
        check("d3.fetch_req",  fetch_req,  1);
        check("d3.fetch_addr", fetch_addr, 16'h0201);
        pop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
